mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
Parameters:
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning busy cycles for MULT/MULTU (legal range 1..31).
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning busy cycles for DIV/DIVU (legal range 1..31).

Ports:
REQ-003 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port MD_start  input  1  qualifies MD_op as a new EX-stage mult/div/move-to operation this cycle.
REQ-006 SHALL have port MD_op  input  4  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; 9-15 treated as NONE.
REQ-007 SHALL have port MD_in1  input  32  rs operand, the same forwarded value that drives ALU_in1.
REQ-008 SHALL have port MD_in2  input  32  rt operand, the same forwarded value that drives ALU_in2.
REQ-009 SHALL have port MD_flush  input  1  kills an in-flight operation.
REQ-010 SHALL have port MD_busy  output  1  high while an operation is in flight; the hazard unit stalls on it.
REQ-011 SHALL have port MD_out  output  32  MFHI/MFLO read data, muxed downstream against ALU_out into EX/MEM.
REQ-012 SHALL have ports HI and LO  output  32 each  architectural HI/LO register values.

Function
REQ-013 SHALL be a 3-state FSM: IDLE, MUL, DIV; a 5-bit cycle counter is loaded on each accepted start.
REQ-014 Accept rule: SHALL accept MD_start only in IDLE with MD_busy=0; MD_start while busy SHALL be ignored with no state change.
REQ-015 Accepted MULT/MULTU at edge T SHALL latch the 64-bit product (signed/unsigned), enter MUL, load counter=MULT_CYCLES, and assert MD_busy from T through the edge that commits.
REQ-016 Accepted DIV/DIVU SHALL do the same with DIV_CYCLES; quotient goes to LO, remainder to HI.
REQ-017 The counter SHALL decrement once per cycle; on the edge where it reaches 0, HI/LO SHALL update, the FSM SHALL return to IDLE, and MD_busy SHALL fall; with MULT_CYCLES=5, busy is high for exactly 5 cycles after the accept edge.
REQ-018 HI/LO SHALL hold their old values for the whole busy window.
REQ-019 Signed division SHALL truncate toward zero; the remainder SHALL take the sign of the dividend.
REQ-020 Divisor of 0 SHALL still consume DIV_CYCLES but leave HI/LO unchanged.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-022 MTHI/MTLO accepted in IDLE SHALL write MD_in1 to HI/LO at that edge, with no busy cycle.
REQ-023 MFHI/MFLO SHALL be combinational: MD_out=HI when MD_op=7, LO when MD_op=8, else 0; this is independent of MD_start and busy.
REQ-024 MD_flush=1 SHALL return the FSM to IDLE next edge, drop MD_busy, and discard the pending result; flush has priority over commit and over a same-cycle start.
REQ-025 MD_busy SHALL be a registered output; there is no combinational path from MD_start to MD_busy.

Reset
REQ-026 reset=0 SHALL immediately force IDLE, counter=0, MD_busy=0, HI=0, LO=0, latched result=0, regardless of clk.
REQ-027 Reset mid-operation SHALL discard the in-flight result; after release, the first edge SHALL accept a new start.

Verification
REQ-028 MULT 0xFFFFFFFF x 0x00000002 -> busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; the same operands with MULTU -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-029 DIV 0xFFFFFFF9 / 0x00000002 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
REQ-030 HI=0x1234 then DIV x/0 -> busy 10 cycles, HI stays 0x1234 and LO is unchanged; signed 0x80000000/-1 -> LO=0x80000000, HI=0.
REQ-031 MULT accepted, then MD_start MTLO at busy cycle 2 -> ignored, LO is the product; MFLO with MD_op=8 during busy -> MD_out shows the old LO.
REQ-032 MULT accepted, then MD_flush at cycle 3 -> busy drops next edge and HI/LO keep their pre-MULT values; a repeat with reset=0 at cycle 3 -> HI=LO=0 and busy=0 asynchronously.
REQ-033 MTHI 0xDEADBEEF, then next cycle MFHI -> MD_out=0xDEADBEEF and busy never asserts.

Source files
------------

// File: rtl/mdu.sv
// ============================================================================
// Module   : mdu
// Purpose  : Multi-cycle multiply/divide unit holding the architectural HI/LO
//            registers, with move-to/move-from support for a MIPS-style EX stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MD_start,
    input  logic [3:0]  MD_op,
    input  logic [31:0] MD_in1,
    input  logic [31:0] MD_in2,
    input  logic        MD_flush,
    output logic        MD_busy,
    output logic [31:0] MD_out,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam logic [4:0] C_MULT_CNT = 5'(MULT_CYCLES);
    localparam logic [4:0] C_DIV_CNT  = 5'(DIV_CYCLES);

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [63:0] res_q, res_d;
    logic        dz_q, dz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        w_idle_start;
    logic        w_done;

    // ------------------------------------------------------------------
    // Arithmetic datapath
    // ------------------------------------------------------------------
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_div_signed;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_den;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    // Low 64 bits of a sign-extended product equal the signed product.
    assign w_prod_s = {{32{MD_in1[31]}}, MD_in1} * {{32{MD_in2[31]}}, MD_in2};
    assign w_prod_u = {32'd0, MD_in1} * {32'd0, MD_in2};

    // Magnitude division: truncates toward zero, remainder follows dividend,
    // and 0x80000000 / -1 wraps back to 0x80000000 naturally.
    assign w_div_signed = (MD_op == OP_DIV);
    assign w_neg_a      = w_div_signed & MD_in1[31];
    assign w_neg_b      = w_div_signed & MD_in2[31];
    assign w_mag_a      = w_neg_a ? (~MD_in1 + 32'd1) : MD_in1;
    assign w_mag_b      = w_neg_b ? (~MD_in2 + 32'd1) : MD_in2;
    assign w_den        = (MD_in2 == 32'd0) ? 32'd1 : w_mag_b;
    assign w_q_mag      = w_mag_a / w_den;
    assign w_r_mag      = w_mag_a % w_den;
    assign w_quot       = (w_neg_a ^ w_neg_b) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem        = w_neg_a ? (~w_r_mag + 32'd1) : w_r_mag;

    assign w_idle_start = (state_q == ST_IDLE) && !busy_q && MD_start && !MD_flush;
    assign w_done       = (cnt_q <= 5'd1);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (MD_flush) begin
            state_d = ST_IDLE;
            cnt_d   = 5'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_idle_start) begin
                        case (MD_op)
                            OP_MULT, OP_MULTU: begin
                                state_d = ST_MUL;
                                cnt_d   = C_MULT_CNT;
                            end
                            OP_DIV, OP_DIVU: begin
                                state_d = ST_DIV;
                                cnt_d   = C_DIV_CNT;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (w_done) begin
                        state_d = ST_IDLE;
                        cnt_d   = 5'd0;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 5'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs and HI/LO/result update
    // ------------------------------------------------------------------
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        res_d  = res_q;
        dz_d   = dz_q;
        hi_d   = hi_q;
        lo_d   = lo_q;

        if (w_idle_start) begin
            case (MD_op)
                OP_MULT:  begin res_d = w_prod_s;        dz_d = 1'b0;               end
                OP_MULTU: begin res_d = w_prod_u;        dz_d = 1'b0;               end
                OP_DIV,
                OP_DIVU:  begin res_d = {w_rem, w_quot}; dz_d = (MD_in2 == 32'd0);  end
                OP_MTHI:  hi_d = MD_in1;
                OP_MTLO:  lo_d = MD_in1;
                default: ;
            endcase
        end

        // A zero divisor still burns the full latency but never commits.
        if (!MD_flush && (state_q != ST_IDLE) && w_done && !dz_q) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_q <= 64'd0;
            dz_q  <= 1'b0;
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
        end else begin
            res_q <= res_d;
            dz_q  <= dz_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    always_comb begin
        case (MD_op)
            OP_MFHI: MD_out = hi_q;
            OP_MFLO: MD_out = lo_q;
            default: MD_out = 32'd0;
        endcase
    end

    assign MD_busy = busy_q;
    assign HI      = hi_q;
    assign LO      = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu.sv
// ============================================================================
// Module   : tb_mdu
// Purpose  : Self-checking bench for mdu: directed corner cases plus random
//            traffic compared against a cycle-count reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic        MD_start;
    logic [3:0]  MD_op;
    logic [31:0] MD_in1;
    logic [31:0] MD_in2;
    logic        MD_flush;
    logic        MD_busy;
    logic [31:0] MD_out;
    logic [31:0] HI;
    logic [31:0] LO;

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk      (clk),
        .reset    (reset),
        .MD_start (MD_start),
        .MD_op    (MD_op),
        .MD_in1   (MD_in1),
        .MD_in2   (MD_in2),
        .MD_flush (MD_flush),
        .MD_busy  (MD_busy),
        .MD_out   (MD_out),
        .HI       (HI),
        .LO       (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: pending result committed at an absolute cycle number.
    longint      cyc = 0;
    logic [31:0] m_hi = 0, m_lo = 0;
    logic        m_busy = 0;
    longint      m_commit_at = 0;
    logic [31:0] m_p_hi = 0, m_p_lo = 0;
    logic        m_p_valid = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_hi = 0; m_lo = 0; m_busy = 0; m_p_valid = 0;
    endtask

    task automatic model_edge(input logic st, input logic [3:0] op,
                              input logic [31:0] a, input logic [31:0] b, input logic fl);
        longint      sa, sb;
        logic [63:0] p;
        cyc++;
        if (fl) begin
            m_busy = 0;
        end else if (m_busy) begin
            if (cyc == m_commit_at) begin
                m_busy = 0;
                if (m_p_valid) begin m_hi = m_p_hi; m_lo = m_p_lo; end
            end
        end else if (st) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            case (op)
                4'd1: begin
                    p = 64'(sa * sb);
                    {m_p_hi, m_p_lo} = p; m_p_valid = 1;
                    m_busy = 1; m_commit_at = cyc + MC;
                end
                4'd2: begin
                    p = {32'd0, a} * {32'd0, b};
                    {m_p_hi, m_p_lo} = p; m_p_valid = 1;
                    m_busy = 1; m_commit_at = cyc + MC;
                end
                4'd3, 4'd4: begin
                    m_p_valid = (b != 0);
                    if (b != 0) begin
                        if (op == 4'd3) begin
                            m_p_lo = 32'(sa / sb);
                            m_p_hi = 32'(sa % sb);
                        end else begin
                            m_p_lo = a / b;
                            m_p_hi = a % b;
                        end
                    end
                    m_busy = 1; m_commit_at = cyc + DC;
                end
                4'd5: m_hi = a;
                4'd6: m_lo = a;
                default: ;
            endcase
        end
    endtask

    // One clock: drive after negedge, check MD_out, then check state after posedge.
    task automatic step(input logic st, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic fl);
        logic [31:0] exp_out;
        @(negedge clk);
        MD_start = st; MD_op = op; MD_in1 = a; MD_in2 = b; MD_flush = fl;
        #1;
        exp_out = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0;
        chk("md_out", MD_out, exp_out);
        model_edge(st, op, a, b, fl);
        @(posedge clk);
        #1;
        chk("busy", {31'd0, MD_busy}, {31'd0, m_busy});
        chk("hi", HI, m_hi);
        chk("lo", LO, m_lo);
    endtask

    task automatic idle_step();
        step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    endtask

    // Accept an op and count cycles until busy drops, bounded.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int nbusy);
        nbusy = 0;
        step(1'b1, op, a, b, 1'b0);
        while (MD_busy && nbusy < 40) begin
            nbusy++;
            idle_step();
        end
    endtask

    logic [31:0] r_a, r_b;
    int          nb;

    initial begin
        reset = 1'b0; MD_start = 0; MD_op = 0; MD_in1 = 0; MD_in2 = 0; MD_flush = 0;
        model_reset();
        #12;
        chk("rst_busy", {31'd0, MD_busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op(4'd1, 32'hFFFFFFFF, 32'h2, nb);
        chk("mult_busy_cycles", nb, 32'd5);
        chk("mult_hi", HI, 32'hFFFFFFFF);
        chk("mult_lo", LO, 32'hFFFFFFFE);
        run_op(4'd2, 32'hFFFFFFFF, 32'h2, nb);
        chk("multu_hi", HI, 32'h00000001);
        chk("multu_lo", LO, 32'hFFFFFFFE);

        run_op(4'd3, 32'hFFFFFFF9, 32'h2, nb);
        chk("div_busy_cycles", nb, 32'd10);
        chk("div_lo", LO, 32'hFFFFFFFD);
        chk("div_hi", HI, 32'hFFFFFFFF);
        run_op(4'd4, 32'd7, 32'd2, nb);
        chk("divu_lo", LO, 32'd3);
        chk("divu_hi", HI, 32'd1);

        step(1'b1, 4'd5, 32'h1234, 32'd0, 1'b0);
        run_op(4'd3, 32'd99, 32'd0, nb);
        chk("div0_busy_cycles", nb, 32'd10);
        chk("div0_hi", HI, 32'h1234);
        chk("div0_lo", LO, 32'd3);
        run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, nb);
        chk("ovf_lo", LO, 32'h80000000);
        chk("ovf_hi", HI, 32'd0);

        // MTLO while busy is ignored; MFLO during busy sees the old LO.
        step(1'b1, 4'd1, 32'd1000, 32'd1000, 1'b0);
        idle_step();
        step(1'b1, 4'd6, 32'hAAAA5555, 32'd0, 1'b0);
        step(1'b0, 4'd8, 32'd0, 32'd0, 1'b0);
        chk("mflo_busy_old", MD_out, 32'h80000000);
        repeat (4) idle_step();
        chk("mult_after_mtlo_lo", LO, 32'd1000000);

        // Flush at cycle 3 discards the product.
        step(1'b1, 4'd2, 32'h12345678, 32'h9ABCDEF0, 1'b0);
        idle_step();
        idle_step();
        step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        chk("flush_busy", {31'd0, MD_busy}, 32'd0);
        chk("flush_lo", LO, 32'd1000000);
        repeat (6) idle_step();
        chk("flush_no_late_commit", LO, 32'd1000000);

        // Asynchronous reset mid-operation.
        step(1'b1, 4'd1, 32'h7, 32'h9, 1'b0);
        idle_step();
        idle_step();
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        chk("arst_busy", {31'd0, MD_busy}, 32'd0);
        chk("arst_hi", HI, 32'd0);
        chk("arst_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        step(1'b1, 4'd5, 32'hDEADBEEF, 32'd0, 1'b0);
        chk("mthi_no_busy", {31'd0, MD_busy}, 32'd0);
        step(1'b0, 4'd7, 32'd0, 32'd0, 1'b0);
        chk("mfhi", MD_out, 32'hDEADBEEF);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            r_a = $urandom;
            r_b = $urandom;
            case ($urandom_range(0, 7))
                0: r_b = 32'd0;
                1: r_b = 32'hFFFFFFFF;
                2: r_a = 32'h80000000;
                3: r_b = $urandom_range(1, 9);
                default: ;
            endcase
            step(($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)), r_a, r_b,
                 ($urandom_range(0, 24) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
